// File: rtl/fifo_credit_based_vc.sv
// Input buffer for a credit-based NoC router port: VC_NUM independent FIFOs of
// DEPTH flits behind one link, one credit returned per popped flit per VC.
module fifo_credit_based_vc #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int VC_NUM     = 2,
   parameter int READ_PORTS = 5,
   localparam int VCW       = $clog2(VC_NUM),
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DATA_WIDTH-1:0]          RX,
   input  logic                           valid_in,
   input  logic [VCW-1:0]                 vc_in,
   input  logic [VC_NUM*READ_PORTS-1:0]   read_en,
   output logic [VC_NUM*DATA_WIDTH-1:0]   Data_out,
   output logic [VC_NUM-1:0]              empty_out,
   output logic [VC_NUM-1:0]              full_out,
   output logic [VC_NUM*CW-1:0]           occupancy,
   output logic [VC_NUM-1:0]              credit_out,
   output logic                           overflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [VCW:0] VC_LIM = (VCW + 1)'(VC_NUM);

   // Handshake: a flit is accepted when valid_in is high and its VC is in
   // range and not full; there is no ready signal, flow control is by credits,
   // so a rejected flit is a protocol violation recorded in overflow_err.
   logic [DATA_WIDTH-1:0] r_mem    [VC_NUM][DEPTH];
   logic [PW-1:0]         r_rd_ptr [VC_NUM];
   logic [PW-1:0]         r_wr_ptr [VC_NUM];
   logic [CW-1:0]         r_count  [VC_NUM];
   logic [VC_NUM-1:0]     r_credit;
   logic                  r_ovf;

   logic [VC_NUM-1:0]     w_sel;
   logic [VC_NUM-1:0]     w_full;
   logic [VC_NUM-1:0]     w_empty;
   logic [VC_NUM-1:0]     w_wr;
   logic [VC_NUM-1:0]     w_pop;
   logic                  w_in_range;
   logic                  w_ovf;

   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_in_range = ({1'b0, vc_in} < VC_LIM);

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      assign w_sel[v]   = (vc_in == VCW'(v));
      assign w_full[v]  = (r_count[v] == CW'(DEPTH));
      assign w_empty[v] = (r_count[v] == '0);
      assign w_wr[v]    = valid_in && w_in_range && w_sel[v] && !w_full[v];
      // Any number of ports reading the same VC collapses into one pop.
      assign w_pop[v]   = (|read_en[v*READ_PORTS +: READ_PORTS]) && !w_empty[v];

      assign Data_out[v*DATA_WIDTH +: DATA_WIDTH] = r_mem[v][r_rd_ptr[v]];
      assign occupancy[v*CW +: CW]                = r_count[v];
   end

   assign w_ovf        = valid_in && (!w_in_range || (|(w_sel & w_full)));
   assign empty_out    = w_empty;
   assign full_out     = w_full;
   assign credit_out   = r_credit;
   assign overflow_err = r_ovf;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int v = 0; v < VC_NUM; v++) begin
            for (int d = 0; d < DEPTH; d++) r_mem[v][d] <= '0;
            r_rd_ptr[v] <= '0;
            r_wr_ptr[v] <= '0;
            r_count[v]  <= '0;
         end
         r_credit <= '0;
         r_ovf    <= 1'b0;
      end else begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (w_wr[v]) begin
               r_mem[v][r_wr_ptr[v]] <= RX;
               r_wr_ptr[v]           <= f_next(r_wr_ptr[v]);
            end
            if (w_pop[v]) r_rd_ptr[v] <= f_next(r_rd_ptr[v]);
            case ({w_wr[v], w_pop[v]})
               2'b10:   r_count[v] <= r_count[v] + CW'(1);
               2'b01:   r_count[v] <= r_count[v] - CW'(1);
               default: r_count[v] <= r_count[v];
            endcase
         end
         r_credit <= w_pop;
         if (w_ovf) r_ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_credit_based_vc.sv
// Bench for fifo_credit_based_vc: a DEPTH=4/2-VC instance and a DEPTH=3/3-VC
// instance, both checked every cycle against a queue-based reference model.
module tb_fifo_credit_based_vc;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Instance A: DEPTH=4, VC_NUM=2 (CW=3)
   logic [31:0] rx_a;
   logic        valid_a;
   logic [0:0]  vc_a;
   logic [9:0]  rd_a;
   logic [63:0] dout_a;
   logic [1:0]  empty_a, full_a, credit_a;
   logic [5:0]  occ_a;
   logic        ovf_a;

   // Instance B: DEPTH=3, VC_NUM=3 (CW=2, vc_in=3 is out of range)
   logic [31:0] rx_b;
   logic        valid_b;
   logic [1:0]  vc_b;
   logic [14:0] rd_b;
   logic [95:0] dout_b;
   logic [2:0]  empty_b, full_b, credit_b;
   logic [5:0]  occ_b;
   logic        ovf_b;

   fifo_credit_based_vc #(.DATA_WIDTH(32), .DEPTH(4), .VC_NUM(2), .READ_PORTS(5)) u_dut_a (
      .clk(clk), .reset(reset), .RX(rx_a), .valid_in(valid_a), .vc_in(vc_a),
      .read_en(rd_a), .Data_out(dout_a), .empty_out(empty_a), .full_out(full_a),
      .occupancy(occ_a), .credit_out(credit_a), .overflow_err(ovf_a));

   fifo_credit_based_vc #(.DATA_WIDTH(32), .DEPTH(3), .VC_NUM(3), .READ_PORTS(5)) u_dut_b (
      .clk(clk), .reset(reset), .RX(rx_b), .valid_in(valid_b), .vc_in(vc_b),
      .read_en(rd_b), .Data_out(dout_b), .empty_out(empty_b), .full_out(full_b),
      .occupancy(occ_b), .credit_out(credit_b), .overflow_err(ovf_b));

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one flit queue per VC per instance, plus flags.
   logic [31:0] mq [2][3][$];
   logic        m_ovf  [2];
   logic [2:0]  m_cred [2];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input int inst, input logic rst, input logic [31:0] rx,
                             input logic valid, input logic [1:0] vc, input logic [14:0] rd);
      int nvc = (inst == 0) ? 2 : 3;
      int dep = (inst == 0) ? 4 : 3;
      logic [2:0] pop = '0;
      logic wr_ok = 1'b0;
      if (rst) begin
         for (int v = 0; v < 3; v++) mq[inst][v].delete();
         m_ovf[inst]  = 1'b0;
         m_cred[inst] = '0;
         return;
      end
      for (int v = 0; v < nvc; v++)
         pop[v] = (((rd >> (v * 5)) & 15'h1f) != 0) && (mq[inst][v].size() > 0);
      if (valid && int'(vc) < nvc) wr_ok = (mq[inst][vc].size() < dep);
      if (valid && !wr_ok) m_ovf[inst] = 1'b1;
      for (int v = 0; v < nvc; v++)
         if (pop[v]) void'(mq[inst][v].pop_front());
      if (wr_ok) mq[inst][vc].push_back(rx);
      m_cred[inst] = pop;
   endtask

   task automatic check_inst(input int inst);
      int nvc = (inst == 0) ? 2 : 3;
      int dep = (inst == 0) ? 4 : 3;
      int cw  = (inst == 0) ? 3 : 2;
      string p = (inst == 0) ? "a" : "b";
      logic [127:0] e_empty = '0, e_full = '0, e_occ = '0;
      for (int v = 0; v < nvc; v++) begin
         e_empty[v] = (mq[inst][v].size() == 0);
         e_full[v]  = (mq[inst][v].size() == dep);
         e_occ      = e_occ | (128'(mq[inst][v].size()) << (v * cw));
      end
      check({p, "_empty"},  (inst == 0) ? 128'(empty_a)  : 128'(empty_b),  e_empty);
      check({p, "_full"},   (inst == 0) ? 128'(full_a)   : 128'(full_b),   e_full);
      check({p, "_occ"},    (inst == 0) ? 128'(occ_a)    : 128'(occ_b),    e_occ);
      check({p, "_credit"}, (inst == 0) ? 128'(credit_a) : 128'(credit_b), 128'(m_cred[inst]));
      check({p, "_ovf"},    (inst == 0) ? 128'(ovf_a)    : 128'(ovf_b),    128'(m_ovf[inst]));
      for (int v = 0; v < nvc; v++)
         if (mq[inst][v].size() > 0)
            check($sformatf("%s_head%0d", p, v),
                  (inst == 0) ? 128'(dout_a[v*32 +: 32]) : 128'(dout_b[v*32 +: 32]),
                  128'(mq[inst][v][0]));
   endtask

   // Advance one clock: step the model on the inputs being presented, then
   // compare every DUT output shortly after the edge.
   task automatic tick();
      model_step(0, reset, rx_a, valid_a, {1'b0, vc_a}, {5'b0, rd_a});
      model_step(1, reset, rx_b, valid_b, vc_b, rd_b);
      @(posedge clk);
      #1;
      check_inst(0);
      check_inst(1);
   endtask

   task automatic idle();
      valid_a = 1'b0; rd_a = '0; rx_a = '0; vc_a = '0;
      valid_b = 1'b0; rd_b = '0; rx_b = '0; vc_b = '0;
   endtask

   task automatic write_a(input logic [0:0] vc, input logic [31:0] d);
      valid_a = 1'b1; vc_a = vc; rx_a = d;
   endtask

   task automatic write_b(input logic [1:0] vc, input logic [31:0] d);
      valid_b = 1'b1; vc_b = vc; rx_b = d;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      rd_a  = '1;
      rd_b  = '1;
      tick();
      tick();
      check("rst_data_a", 128'(dout_a), '0);
      check("rst_data_b", 128'(dout_b), '0);
      reset = 1'b0;
      idle();

      // Fill VC0 of A, then one write too many.
      for (int i = 0; i < 5; i++) begin
         write_a(1'b0, 32'hA1 + i);
         tick();
      end
      check("fill_full_a", 128'(full_a), 128'(2'b01));
      idle();

      // Drain VC0 through port N, plus one read of the empty VC.
      for (int i = 0; i < 5; i++) begin
         rd_a = 10'b00000_00001;
         tick();
      end
      idle();
      tick();

      // Fill VC1, then write+pop at full, then write+pop at occupancy 2.
      for (int i = 0; i < 4; i++) begin
         write_a(1'b1, 32'hB1 + i);
         tick();
      end
      write_a(1'b1, 32'hB5);
      rd_a = 10'b00001_00000;
      tick();
      idle();
      rd_a = 10'b00100_00000;
      tick();
      write_a(1'b1, 32'hB6);
      rd_a = 10'b10000_00000;
      tick();
      check("wrpop_occ_a", 128'(occ_a[5:3]), 128'(3'd2));
      idle();

      // Two ports on VC0 while VC1 is written.
      write_a(1'b0, 32'hC1);
      tick();
      write_a(1'b0, 32'hC2);
      tick();
      write_a(1'b1, 32'hC3);
      rd_a = 10'b00000_10001;
      tick();
      check("multiport_cred_a", 128'(credit_a), 128'(2'b01));
      idle();

      // B: wrap-around with interleaved write/pop on VC0, then sustained rate.
      for (int i = 0; i < 10; i++) begin
         write_b(2'd0, 32'h100 + i);
         tick();
         idle();
         rd_b = 15'h0001 << (i % 5);
         tick();
         idle();
      end
      write_b(2'd0, 32'h200);
      tick();
      for (int i = 1; i < 8; i++) begin
         write_b(2'd0, 32'h200 + i);
         rd_b = 15'h0002;
         tick();
      end
      idle();
      write_b(2'd3, 32'hDEAD);
      tick();
      check("oor_ovf_b", 128'(ovf_b), 128'(1'b1));
      idle();

      // Reset mid-traffic with reads asserted.
      write_a(1'b0, 32'hE1);
      tick();
      write_a(1'b0, 32'hE2);
      tick();
      idle();
      reset = 1'b1;
      rd_a  = '1;
      rd_b  = '1;
      tick();
      check("midrst_data_a", 128'(dout_a), '0);
      check("midrst_data_b", 128'(dout_b), '0);
      reset = 1'b0;
      idle();

      // Random traffic on both instances.
      for (int i = 0; i < 400; i++) begin
         valid_a = ($urandom_range(0, 3) != 0);
         vc_a    = 1'($urandom_range(0, 1));
         rx_a    = $urandom;
         rd_a    = 10'($urandom) & 10'($urandom);
         valid_b = ($urandom_range(0, 3) != 0);
         vc_b    = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         rx_b    = $urandom;
         rd_b    = 15'($urandom) & 15'($urandom);
         reset   = ($urandom_range(0, 99) == 0);
         tick();
      end
      reset = 1'b0;
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
